// File: rtl/rob_pkg.sv
// Shared retirement-buffer types: depth, tag width and the per-entry record.
// Dispatch and the execution lanes import the same tag type from here.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_WIDTH = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [4:0]           rd;
    logic [ROB_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, completion and register-file write signals of the retirement buffer.
// The slave side is the buffer; the master side is dispatch, the lanes and the regfile.
interface rob_commit_if import rob_pkg::*; #(
  parameter int unsigned WIDTH = ROB_WIDTH,
  parameter int unsigned TAG_W = ROB_TAG_W
);

  logic             flush_i;
  logic             alloc_valid_i;
  logic [4:0]       alloc_rd_addr_i;
  logic             alloc_ready_o;
  logic [TAG_W-1:0] alloc_tag_o;
  logic             cmpl1_valid_i;
  logic [TAG_W-1:0] cmpl1_tag_i;
  logic [WIDTH-1:0] cmpl1_data_i;
  logic             cmpl2_valid_i;
  logic [TAG_W-1:0] cmpl2_tag_i;
  logic [WIDTH-1:0] cmpl2_data_i;
  logic             cmpl3_valid_i;
  logic [TAG_W-1:0] cmpl3_tag_i;
  logic [WIDTH-1:0] cmpl3_data_i;
  logic             w_en_o;
  logic [4:0]       rd_addr_o;
  logic [WIDTH-1:0] w_data_o;
  logic             empty_o;
  logic [TAG_W:0]   count_o;

  modport slave (
    input  flush_i, alloc_valid_i, alloc_rd_addr_i,
    input  cmpl1_valid_i, cmpl1_tag_i, cmpl1_data_i,
    input  cmpl2_valid_i, cmpl2_tag_i, cmpl2_data_i,
    input  cmpl3_valid_i, cmpl3_tag_i, cmpl3_data_i,
    output alloc_ready_o, alloc_tag_o, w_en_o, rd_addr_o, w_data_o, empty_o, count_o
  );

  modport master (
    output flush_i, alloc_valid_i, alloc_rd_addr_i,
    output cmpl1_valid_i, cmpl1_tag_i, cmpl1_data_i,
    output cmpl2_valid_i, cmpl2_tag_i, cmpl2_data_i,
    output cmpl3_valid_i, cmpl3_tag_i, cmpl3_data_i,
    input  alloc_ready_o, alloc_tag_o, w_en_o, rd_addr_o, w_data_o, empty_o, count_o
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping buffer pointer with synchronous clear and increment enable.
// Wrap-around is implicit because the depth is a power of two.
module rob_ptr #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + Width'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit.sv
// In-order retirement buffer: program-order allocation, out-of-order completion by tag,
// at most one retire per cycle onto the register file write port.
module rob_commit import rob_pkg::*; #(
  parameter int unsigned WIDTH = ROB_WIDTH,
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = ROB_TAG_W
) (
  input logic         clk_i,
  input logic         reset_i,
  rob_commit_if.slave bus
);

  localparam int unsigned NumLanes = 3;
  localparam logic [TAG_W:0] DepthCnt = (TAG_W+1)'(DEPTH);

  rob_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [TAG_W:0]         count_q, count_d;
  logic [TAG_W-1:0]       head, tail;
  logic                   alloc_fire, retire;

  logic [NumLanes-1:0] cv;
  logic [TAG_W-1:0]    ct [NumLanes];
  logic [WIDTH-1:0]    cd [NumLanes];

  assign cv    = {bus.cmpl3_valid_i, bus.cmpl2_valid_i, bus.cmpl1_valid_i};
  assign ct[0] = bus.cmpl1_tag_i;
  assign ct[1] = bus.cmpl2_tag_i;
  assign ct[2] = bus.cmpl3_tag_i;
  assign cd[0] = bus.cmpl1_data_i;
  assign cd[1] = bus.cmpl2_data_i;
  assign cd[2] = bus.cmpl3_data_i;

  // Readiness looks only at count, so a slot freed by a same-cycle retire is not reused.
  assign bus.alloc_ready_o = (count_q < DepthCnt);
  assign alloc_fire        = bus.alloc_valid_i & bus.alloc_ready_o & ~bus.flush_i;
  assign retire            = ent_q[head].valid & ent_q[head].done & ~bus.flush_i;

  assign bus.w_en_o      = retire & (ent_q[head].rd != 5'd0);
  assign bus.rd_addr_o   = ent_q[head].rd;
  assign bus.w_data_o    = ent_q[head].data;
  assign bus.alloc_tag_o = tail;
  assign bus.count_o     = count_q;
  assign bus.empty_o     = (count_q == '0);

  always_comb begin
    ent_d = ent_q;
    // Highest lane applied first so lane 1 wins a same-tag collision.
    for (int l = NumLanes - 1; l >= 0; l--) begin
      if (cv[l] && ent_q[ct[l]].valid) begin
        ent_d[ct[l]].done = 1'b1;
        ent_d[ct[l]].data = cd[l];
      end
    end
    if (retire) begin
      ent_d[head] = '0;
    end
    if (alloc_fire) begin
      ent_d[tail] = '{valid: 1'b1, done: 1'b0, rd: bus.alloc_rd_addr_i, data: '0};
    end
    if (bus.flush_i) begin
      ent_d = '0;
    end
  end

  always_comb begin
    count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire};
    if (bus.flush_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  rob_ptr #(.Width(TAG_W)) u_head (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (bus.flush_i),
    .inc_i   (retire),
    .ptr_o   (head)
  );

  rob_ptr #(.Width(TAG_W)) u_tail (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (bus.flush_i),
    .inc_i   (alloc_fire),
    .ptr_o   (tail)
  );

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a program-order queue model predicts every regfile
// write and per-cycle status; a negedge monitor compares what the buffer presents.
module tb_rob_commit;
  import rob_pkg::*;

  localparam int unsigned DEPTH = ROB_DEPTH;
  localparam int unsigned WIDTH = ROB_WIDTH;
  localparam int unsigned TAG_W = ROB_TAG_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rob_commit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  rob_commit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct {
    int               tag;
    logic [4:0]       rd;
    bit               done;
    logic [WIDTH-1:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
    int               cyc;
  } wr_t;

  ent_t rob_q[$];
  wr_t  exp_q[$];
  wr_t  log_q[$];
  wr_t  mon_e;
  int   next_tag = 0;
  bit   chk_en = 1'b0;
  int   cur_count = 0;
  int   cur_tag = 0;
  bit   cur_wen = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Staged stimulus for the next cycle.
  bit               s_reset = 1'b0;
  bit               s_flush = 1'b0;
  bit               s_av = 1'b0;
  logic [4:0]       s_ard = '0;
  bit               s_cv [3];
  int               s_ct [3];
  logic [WIDTH-1:0] s_cd [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: advance one cycle from the staged inputs.
  function automatic void model_step();
    bit retire;
    if (s_reset) begin
      rob_q.delete();
      next_tag = 0;
      chk_en   = 1'b0;
      return;
    end
    chk_en    = 1'b1;
    cur_count = rob_q.size();
    cur_tag   = next_tag;
    retire    = (rob_q.size() > 0) && rob_q[0].done && !s_flush;
    cur_wen   = retire && (rob_q[0].rd != 5'd0);
    if (cur_wen) exp_q.push_back('{rd: rob_q[0].rd, data: rob_q[0].data, cyc: 0});
    if (s_flush) begin
      rob_q.delete();
      next_tag = 0;
      return;
    end
    for (int l = 2; l >= 0; l--) begin
      if (s_cv[l]) begin
        for (int i = 0; i < rob_q.size(); i++) begin
          if (rob_q[i].tag == s_ct[l]) begin
            rob_q[i].done = 1'b1;
            rob_q[i].data = s_cd[l];
          end
        end
      end
    end
    if (retire) void'(rob_q.pop_front());
    if (s_av && cur_count < int'(DEPTH)) begin
      rob_q.push_back('{tag: next_tag, rd: s_ard, done: 1'b0, data: '0});
      next_tag = (next_tag + 1) % DEPTH;
    end
  endfunction

  task automatic issue();
    @(posedge clk);
    #1;
    reset               = s_reset;
    bus.flush_i         = s_flush;
    bus.alloc_valid_i   = s_av;
    bus.alloc_rd_addr_i = s_ard;
    bus.cmpl1_valid_i   = s_cv[0];
    bus.cmpl1_tag_i     = TAG_W'(s_ct[0]);
    bus.cmpl1_data_i    = s_cd[0];
    bus.cmpl2_valid_i   = s_cv[1];
    bus.cmpl2_tag_i     = TAG_W'(s_ct[1]);
    bus.cmpl2_data_i    = s_cd[1];
    bus.cmpl3_valid_i   = s_cv[2];
    bus.cmpl3_tag_i     = TAG_W'(s_ct[2]);
    bus.cmpl3_data_i    = s_cd[2];
    model_step();
    s_reset = 1'b0;
    s_flush = 1'b0;
    s_av    = 1'b0;
    s_ard   = '0;
    for (int l = 0; l < 3; l++) begin
      s_cv[l] = 1'b0;
      s_ct[l] = 0;
      s_cd[l] = '0;
    end
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    s_av  = 1'b1;
    s_ard = rd;
    issue();
  endtask

  task automatic set_cmpl(input int lane, input int tag, input logic [WIDTH-1:0] d);
    s_cv[lane-1] = 1'b1;
    s_ct[lane-1] = tag;
    s_cd[lane-1] = d;
  endtask

  task automatic do_reset();
    s_reset = 1'b1;
    issue();
    issue();
  endtask

  task automatic check_wr(input int i, input logic [4:0] rd, input logic [WIDTH-1:0] d);
    if (i < log_q.size()) begin
      check($sformatf("log%0d_rd", i), log_q[i].rd, rd);
      check($sformatf("log%0d_data", i), log_q[i].data, d);
    end else begin
      fail_now($sformatf("log%0d_missing", i));
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: status against the model every cycle, writes against the expected queue.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", bus.count_o, cur_count);
      check("empty", bus.empty_o, cur_count == 0);
      check("alloc_ready", bus.alloc_ready_o, cur_count < int'(DEPTH));
      check("alloc_tag", bus.alloc_tag_o, cur_tag);
      check("w_en", bus.w_en_o, cur_wen);
      if (bus.w_en_o || cur_wen) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.w_en_o) begin
            check("wr_rd", bus.rd_addr_o, mon_e.rd);
            check("wr_data", bus.w_data_o, mon_e.data);
            log_q.push_back('{rd: bus.rd_addr_o, data: bus.w_data_o, cyc: cyc});
          end
        end
      end
    end
  end

  initial begin
    bus.flush_i = 1'b0;
    bus.alloc_valid_i = 1'b0;
    bus.alloc_rd_addr_i = '0;
    bus.cmpl1_valid_i = 1'b0;
    bus.cmpl1_tag_i = '0;
    bus.cmpl1_data_i = '0;
    bus.cmpl2_valid_i = 1'b0;
    bus.cmpl2_tag_i = '0;
    bus.cmpl2_data_i = '0;
    bus.cmpl3_valid_i = 1'b0;
    bus.cmpl3_tag_i = '0;
    bus.cmpl3_data_i = '0;
    for (int l = 0; l < 3; l++) begin
      s_cv[l] = 1'b0;
      s_ct[l] = 0;
      s_cd[l] = '0;
    end

    // Reset state
    do_reset();
    issue();
    #1;
    check("rst_count", bus.count_o, 0);
    check("rst_empty", bus.empty_o, 1);
    check("rst_tag", bus.alloc_tag_o, 0);
    check("rst_ready", bus.alloc_ready_o, 1);
    check("rst_w_en", bus.w_en_o, 0);
    check("rst_rd_addr", bus.rd_addr_o, 0);
    check("rst_w_data", bus.w_data_o, 0);

    // In-order retire under out-of-order completion
    log_q.delete();
    do_alloc(5'd5);
    do_alloc(5'd6);
    do_alloc(5'd7);
    set_cmpl(3, 2, 'h30);
    issue();
    set_cmpl(1, 0, 'h10);
    issue();
    set_cmpl(2, 1, 'h20);
    issue();
    repeat (4) issue();
    check("ooo_writes", log_q.size(), 3);
    check_wr(0, 5'd5, 'h10);
    check_wr(1, 5'd6, 'h20);
    check_wr(2, 5'd7, 'h30);
    if (log_q.size() == 3) begin
      check("ooo_consec1", log_q[1].cyc - log_q[0].cyc, 1);
      check("ooo_consec2", log_q[2].cyc - log_q[1].cyc, 1);
    end

    // Fill, ignored 9th request, wrap to tag 0
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(5'(i + 1));
    issue();
    #1;
    check("full_ready", bus.alloc_ready_o, 0);
    check("full_count", bus.count_o, 8);
    do_alloc(5'd9);
    issue();
    #1;
    check("ninth_count", bus.count_o, 8);
    check("ninth_tag", bus.alloc_tag_o, 0);
    set_cmpl(1, 0, 'hA0);
    issue();
    issue();
    #1;
    check("full_retire_w_en", bus.w_en_o, 1);
    do_alloc(5'd10);
    #1;
    check("after_retire_ready", bus.alloc_ready_o, 1);
    check("wrap_tag", bus.alloc_tag_o, 0);
    issue();
    #1;
    check("refill_count", bus.count_o, 8);

    // x0 destination retires silently
    do_reset();
    do_alloc(5'd0);
    set_cmpl(2, 0, 'hDEAD);
    issue();
    log_q.delete();
    issue();
    #1;
    check("x0_w_en", bus.w_en_o, 0);
    check("x0_count_before", bus.count_o, 1);
    issue();
    #1;
    check("x0_count_after", bus.count_o, 0);
    check("x0_no_write", log_q.size(), 0);

    // Flush with pending work and a ready head
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(5'(i + 1));
    set_cmpl(1, 0, 'h11);
    set_cmpl(2, 1, 'h22);
    issue();
    log_q.delete();
    s_flush = 1'b1;
    set_cmpl(1, 2, 'h33);
    issue();
    #1;
    check("flush_w_en", bus.w_en_o, 0);
    issue();
    #1;
    check("flush_count", bus.count_o, 0);
    check("flush_tag", bus.alloc_tag_o, 0);
    repeat (3) issue();
    check("flush_no_write", log_q.size(), 0);

    // Simultaneous allocate, retire and three completions; then a same-tag collision
    do_reset();
    do_alloc(5'd11);
    do_alloc(5'd12);
    s_av  = 1'b1;
    s_ard = 5'd13;
    set_cmpl(1, 0, 'h100);
    issue();
    log_q.delete();
    s_av  = 1'b1;
    s_ard = 5'd14;
    set_cmpl(1, 1, 'h101);
    set_cmpl(2, 2, 'h102);
    set_cmpl(3, 0, 'h1FF);
    issue();
    #1;
    check("sim_count_before", bus.count_o, 3);
    issue();
    #1;
    check("sim_count_after", bus.count_o, 3);
    set_cmpl(1, 3, 'hAAA);
    set_cmpl(2, 3, 'hBBB);
    issue();
    repeat (3) issue();
    check("sim_writes", log_q.size(), 4);
    check_wr(0, 5'd11, 'h100);
    check_wr(1, 5'd12, 'h101);
    check_wr(2, 5'd13, 'h102);
    check_wr(3, 5'd14, 'hAAA);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s_reset = ($urandom_range(0, 199) == 0);
      s_flush = ($urandom_range(0, 99) < 3);
      s_av    = ($urandom_range(0, 99) < 60);
      s_ard   = 5'($urandom);
      for (int l = 0; l < 3; l++) begin
        s_cv[l] = ($urandom_range(0, 99) < 45);
        s_ct[l] = $urandom_range(0, DEPTH - 1);
        s_cd[l] = $urandom;
      end
      issue();
    end
    repeat (2) issue();
    check("exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
